// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter:
// ALU op codes, FSM state encoding and the illegal-op check.
package alu_arbiter_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SRL = 3'd4;
    localparam logic [2:0] ALU_SRA = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic op_illegal(input logic [2:0] op);
        return op > ALU_SRA;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add, sub, and, or, logical/arithmetic right shift.
// Unknown op codes produce zero.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  aluop,
    output logic [31:0] c
);

    // Shifts use the full 32-bit amount, so b >= 32 drains or sign-fills.
    always_comb begin
        c = '0;
        case (aluop)
            ALU_ADD: c = a + b;
            ALU_SUB: c = a - b;
            ALU_AND: c = a & b;
            ALU_OR:  c = a | b;
            ALU_SRL: c = a >> b;
            ALU_SRA: c = $unsigned($signed(a) >>> b);
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters; one op in flight,
// result held on the winner's response channel until accepted.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid0,
    input  logic        req_valid1,
    output logic        req_ready0,
    output logic        req_ready1,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_b1,
    input  logic [2:0]  req_op0,
    input  logic [2:0]  req_op1,
    output logic        rsp_valid0,
    output logic        rsp_valid1,
    input  logic        rsp_ready0,
    input  logic        rsp_ready1,
    output logic [31:0] rsp_c,
    output logic        rsp_err,
    output logic        busy
);

    state_t      state;
    state_t      state_nx;
    logic        owner;
    logic        prio;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  op_q;
    logic [31:0] alu_c;
    logic        grant1;
    logic        idle_ok;
    logic        req_fire;
    logic        rsp_fire;

    always_comb begin
        grant1 = 1'b0;
        unique case (1'b1)
            req_valid0 && req_valid1:  grant1 = RR_EN && prio;
            req_valid1 && !req_valid0: grant1 = 1'b1;
            default:                   grant1 = 1'b0;
        endcase
    end

    assign idle_ok    = (state == S_IDLE) && !reset;
    assign req_ready0 = idle_ok && req_valid0 && !grant1;
    assign req_ready1 = idle_ok && grant1;
    assign req_fire   = req_ready0 || req_ready1;

    assign rsp_valid0 = (state == S_RESP) && !owner;
    assign rsp_valid1 = (state == S_RESP) && owner;
    assign rsp_fire   = (rsp_valid0 && rsp_ready0) ||
                        (rsp_valid1 && rsp_ready1);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (req_fire) state_nx = S_EXEC;
            S_EXEC:  state_nx = S_RESP;
            S_RESP:  if (rsp_fire) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            owner   <= 1'b0;
            prio    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            rsp_c   <= '0;
            rsp_err <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != S_IDLE);
            if (req_fire) begin
                owner <= grant1;
                a_q   <= grant1 ? req_a1 : req_a0;
                b_q   <= grant1 ? req_b1 : req_b0;
                op_q  <= grant1 ? req_op1 : req_op0;
            end
            if (state == S_EXEC) begin
                rsp_c   <= alu_c;
                rsp_err <= op_illegal(op_q);
            end
            if (rsp_fire) begin
                prio <= !owner;
            end
        end
    end

    alu u_alu (
        .a     (a_q),
        .b     (b_q),
        .aluop (op_q),
        .c     (alu_c)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus random traffic,
// a round-robin instance and a fixed-priority instance.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        v0, v1, rr0, rr1;
    logic [31:0] a0, a1, b0, b1;
    logic [2:0]  op0, op1;
    logic        rdy0, rdy1, rv0, rv1, err, busy;
    logic [31:0] c;

    logic        fv, fr0, fr1, frv0, frv1, ferr, fbusy;
    logic        frr;
    logic [31:0] fa, fb, fc;
    logic [2:0]  fop;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid0(v0), .req_valid1(v1),
        .req_ready0(rdy0), .req_ready1(rdy1),
        .req_a0(a0), .req_a1(a1), .req_b0(b0), .req_b1(b1),
        .req_op0(op0), .req_op1(op1),
        .rsp_valid0(rv0), .rsp_valid1(rv1),
        .rsp_ready0(rr0), .rsp_ready1(rr1),
        .rsp_c(c), .rsp_err(err), .busy(busy)
    );

    alu_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .req_valid0(fv), .req_valid1(fv),
        .req_ready0(fr0), .req_ready1(fr1),
        .req_a0(fa), .req_a1(fa), .req_b0(fb), .req_b1(fb),
        .req_op0(fop), .req_op1(fop),
        .rsp_valid0(frv0), .rsp_valid1(frv1),
        .rsp_ready0(frr), .rsp_ready1(frr),
        .rsp_c(fc), .rsp_err(ferr), .busy(fbusy)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference ALU: shifts are done one bit position at a time.
    function automatic logic [32:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [2:0] op);
        logic [31:0] r;
        r = a;
        case (op)
            3'd0: return {1'b0, a + b};
            3'd1: return {1'b0, a - b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: begin
                for (int i = 0; i < 32 && $unsigned(i) < b; i++)
                    r = {1'b0, r[31:1]};
                return {1'b0, r};
            end
            3'd5: begin
                for (int i = 0; i < 32 && $unsigned(i) < b; i++)
                    r = {r[31], r[31:1]};
                return {1'b0, r};
            end
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    typedef struct packed {
        logic        own;
        logic        err;
        logic [31:0] c;
    } exp_t;

    exp_t        q[$];
    exp_t        fq[$];
    bit          inflight;
    int          age;
    logic        mown, mprio;
    int          fgr0;

    // Monitor for the round-robin instance.
    always @(negedge clk) begin
        logic        g0, g1, hit;
        logic [32:0] m;
        if (reset) begin
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_rsp_valid", 32'({rv1, rv0}), 32'd0);
            check("rst_rsp_c", c, 32'd0);
            check("rst_rsp_err", 32'(err), 32'd0);
            check("rst_req_ready", 32'({rdy1, rdy0}), 32'd0);
            inflight = 0;
            age = 0;
            mprio = 1'b0;
            mown = 1'b0;
            q.delete();
        end else begin
            hit = inflight && age >= 2;
            check("busy", 32'(busy), 32'(inflight));
            check("rsp_valid", 32'({rv1, rv0}),
                  32'({hit && mown, hit && !mown}));
            if (hit) begin
                if (q.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    check("rsp_c", c, q[0].c);
                    check("rsp_err", 32'(err), 32'(q[0].err));
                end
            end
            g0 = 1'b0;
            g1 = 1'b0;
            if (inflight) begin
                check("req_ready_busy", 32'({rdy1, rdy0}), 32'd0);
            end else begin
                g0 = v0 && (!v1 || !mprio);
                g1 = v1 && !g0;
                check("grant", 32'({rdy1, rdy0}), 32'({g1, g0}));
            end
            if (inflight) begin
                if (hit && (mown ? rr1 : rr0)) begin
                    if (q.size() != 0) void'(q.pop_front());
                    inflight = 0;
                    mprio = !mown;
                end else if (age < 2) begin
                    age++;
                end
            end else if (g0 || g1) begin
                m = g1 ? model(a1, b1, op1) : model(a0, b0, op0);
                q.push_back('{own: g1, err: m[32], c: m[31:0]});
                mown = g1;
                inflight = 1;
                age = 1;
            end
        end
    end

    // Monitor for the fixed-priority instance.
    always @(negedge clk) begin
        logic [32:0] m;
        if (reset) begin
            check("fp_rst_busy", 32'(fbusy), 32'd0);
            fq.delete();
        end else begin
            check("fp_rsp_valid1", 32'(frv1), 32'd0);
            if (fv) check("fp_req_ready1", 32'(fr1), 32'd0);
            if (frv0) begin
                if (fq.size() == 0) begin
                    check("fp_scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    check("fp_rsp_c", fc, fq[0].c);
                    check("fp_rsp_err", 32'(ferr), 32'(fq[0].err));
                    void'(fq.pop_front());
                end
            end
            if (fr0) begin
                m = model(fa, fb, fop);
                fq.push_back('{own: 1'b0, err: m[32], c: m[31:0]});
                fgr0++;
            end
        end
    end

    initial begin
        fv = 1'b0;
        frr = 1'b1;
        fa = '0;
        fb = '0;
        fop = '0;
        fgr0 = 0;
        wait (reset === 1'b0);
        @(posedge clk);
        #1;
        fv = 1'b1;
        for (int i = 0; i < 40; i++) begin
            fa = $urandom;
            fb = $urandom_range(0, 40);
            fop = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        fv = 1'b0;
    end

    // Hold valids until accepted, then drop them.
    task automatic run(input int n);
        logic s0, s1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s0 = rdy0;
            s1 = rdy1;
            @(posedge clk);
            #1;
            if (s0) v0 = 1'b0;
            if (s1) v1 = 1'b0;
        end
    endtask

    task automatic wait_rsp(input bit which, input logic [31:0] ce,
                            input logic ee, input string name);
        logic s0, s1, hit, found;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            s0 = rdy0;
            s1 = rdy1;
            hit = which ? rv1 : rv0;
            if (hit) begin
                check({name, "_c"}, c, ce);
                check({name, "_err"}, 32'(err), 32'(ee));
                found = 1'b1;
            end
            @(posedge clk);
            #1;
            if (s0) v0 = 1'b0;
            if (s1) v1 = 1'b0;
        end
        check({name, "_timeout"}, 32'(found), 32'd1);
    endtask

    task automatic op0_case(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input logic [31:0] ce,
                            input logic ee, input string name);
        a0 = a;
        b0 = b;
        op0 = op;
        v0 = 1'b1;
        wait_rsp(1'b0, ce, ee, name);
    endtask

    initial begin
        reset = 1'b1;
        rr0 = 1'b1;
        rr1 = 1'b1;
        a0 = 32'd1;
        b0 = 32'd1;
        op0 = 3'd0;
        a1 = 32'h0000_F0F0;
        b1 = 32'h0000_0FF0;
        op1 = 3'd2;
        v0 = 1'b1;
        v1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        wait_rsp(1'b0, 32'd2, 1'b0, "contend_req0");
        wait_rsp(1'b1, 32'h0000_00F0, 1'b0, "contend_req1");

        op0_case(32'd5, 32'd3, 3'd1, 32'd2, 1'b0, "single");

        a1 = 32'h8000_0000;
        b1 = 32'd4;
        op1 = 3'd5;
        v1 = 1'b1;
        rr1 = 1'b0;
        run(1);
        a0 = 32'd7;
        b0 = 32'd9;
        op0 = 3'd0;
        v0 = 1'b1;
        wait_rsp(1'b1, 32'hF800_0000, 1'b0, "bp");
        run(4);
        @(negedge clk);
        check("bp_hold_c", c, 32'hF800_0000);
        check("bp_hold_valid1", 32'(rv1), 32'd1);
        check("bp_req_ready0", 32'(rdy0), 32'd0);
        @(posedge clk);
        #1;
        rr1 = 1'b1;
        wait_rsp(1'b0, 32'd16, 1'b0, "bp_next");

        a1 = 32'd3;
        b1 = 32'd4;
        op1 = 3'd0;
        v1 = 1'b1;
        run(1);
        reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_valid", 32'({rv1, rv0}), 32'd0);
        check("async_rst_c", c, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        a0 = 32'd10;
        b0 = 32'd6;
        op0 = 3'd1;
        a1 = 32'd2;
        b1 = 32'd3;
        op1 = 3'd3;
        v0 = 1'b1;
        v1 = 1'b1;
        wait_rsp(1'b0, 32'd4, 1'b0, "post_rst_req0");
        wait_rsp(1'b1, 32'd3, 1'b0, "post_rst_req1");

        op0_case(32'hFFFF_FFFF, 32'd32, 3'd4, 32'd0, 1'b0, "srl_32");
        op0_case(32'h8000_0000, 32'd40, 3'd5, 32'hFFFF_FFFF, 1'b0, "sra_40");
        op0_case(32'h1234_5678, 32'd1, 3'd6, 32'd0, 1'b1, "illegal_6");

        for (int i = 0; i < 400; i++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            rr0 = 1'($urandom);
            rr1 = 1'($urandom);
            a0 = $urandom;
            a1 = $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
            b1 = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
            op0 = 3'($urandom_range(0, 7));
            op1 = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        v0 = 1'b0;
        v1 = 1'b0;
        rr0 = 1'b1;
        rr1 = 1'b1;
        run(6);

        check("fp_grants0_min4", 32'(fgr0 >= 4), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
